// File: rtl/bitwise_pipe.sv
// bitwise_pipe: pipelined bitwise logic unit with valid/ready on both sides.
// The result and its zr/ng flags are formed at the input and carried
// together through DEPTH elastic stages. Bubbles collapse, so the pipe can
// buffer DEPTH beats while the consumer stalls.
module bitwise_pipe #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zr,
  output logic             ng
);

  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic             zr;
    logic             ng;
  } pay_t;

  logic [DEPTH-1:0] vld_q;
  pay_t [DEPTH-1:0] pay_q;

  logic [DEPTH-1:0] load;
  logic [DEPTH-1:0] adv;
  logic [DEPTH-1:0] vld_in;
  pay_t [DEPTH-1:0] pay_in;
  logic [WIDTH-1:0] res_d;

  // Opcode decode: pure bitwise ops, no carries.
  always_comb begin
    res_d = '0;
    case (op)
      3'b000:  res_d = a & b;
      3'b001:  res_d = a | b;
      3'b010:  res_d = a ^ b;
      3'b011:  res_d = ~(a & b);
      3'b100:  res_d = ~(a | b);
      3'b101:  res_d = ~(a ^ b);
      3'b110:  res_d = ~a;
      default: res_d = a;
    endcase
  end

  // Backpressure chain: walk from the output stage back to stage 0 so a
  // free slot anywhere downstream lets every stage behind it advance.
  always_comb begin
    adv           = '0;
    load          = '0;
    adv[DEPTH-1]  = vld_q[DEPTH-1] & out_ready;
    load[DEPTH-1] = ~vld_q[DEPTH-1] | adv[DEPTH-1];
    for (int i = DEPTH - 2; i >= 0; i--) begin
      adv[i]  = vld_q[i] & load[i+1];
      load[i] = ~vld_q[i] | adv[i];
    end
  end

  // What each stage would take in if it loads this cycle.
  always_comb begin
    vld_in        = '0;
    pay_in        = '0;
    vld_in[0]     = in_valid;
    pay_in[0].res = res_d;
    pay_in[0].zr  = (res_d == '0);
    pay_in[0].ng  = res_d[WIDTH-1];
    for (int i = 1; i < DEPTH; i++) begin
      vld_in[i] = adv[i-1];
      pay_in[i] = pay_q[i-1];
    end
  end

  // Stage registers; payload only captured with a valid beat so idle X on
  // the operands never lands in the pipe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_q <= '0;
      pay_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (load[i]) vld_q[i] <= vld_in[i];
        if (load[i] && vld_in[i]) pay_q[i] <= pay_in[i];
      end
    end
  end

  assign in_ready  = load[0];
  assign out_valid = vld_q[DEPTH-1];
  assign out       = pay_q[DEPTH-1].res;
  assign zr        = pay_q[DEPTH-1].zr;
  assign ng        = pay_q[DEPTH-1].ng;

endmodule
